// File: rtl/cpu_bus_cycle.sv
// cpu_bus_cycle: SM83 M-cycle/T-cycle sequencer and system-bus access unit with wait states and timeout.
// Build option: define CPU_BUS_CYCLE_DOUBLE_SPEED_EN to add speed_switch_req/double_speed.
//
// state  | meaning
// IDLE   | internal M-cycle; at T0 a request may be sampled
// ACTIVE | bus access in progress, T-cycle counter running
// WAIT   | bus access stalled at T_PER_M-2 while bus_wait is high
module cpu_bus_cycle #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int T_PER_M  = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ce,
    input  logic                       req_valid,
    input  logic                       req_write,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    output logic                       req_ready,
    output logic                       commit,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic [$clog2(T_PER_M)-1:0] t_cycle,
    output logic                       phi,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic                       bus_en,
    output logic                       bus_wr,
    output logic [DATA_W-1:0]          bus_wdata,
    input  logic [DATA_W-1:0]          bus_rdata,
    input  logic                       bus_wait,
`ifdef CPU_BUS_CYCLE_DOUBLE_SPEED_EN
    input  logic                       speed_switch_req,
    output logic                       double_speed,
`endif
    output logic                       timeout_err
);

    localparam int TW = $clog2(T_PER_M);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [TW-1:0] T_LAST1 = TW'(T_PER_M - 1);
    localparam logic [TW-1:0] T_WAIT  = TW'(T_PER_M - 2);
    localparam logic [TW-1:0] T_HALF  = TW'(T_PER_M / 2);
    localparam logic [WW-1:0] W_MAX   = WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_t;
    logic [TW-1:0]   w_t_nxt;
    logic [TW-1:0]   w_t_adv;
    logic [WW-1:0]   r_wait_cnt;
    logic [WW-1:0]   w_wait_cnt_nxt;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic            r_write;
    logic            r_abort;
    logic            r_rsp_valid;
    logic            r_timeout;
    logic            w_start;
    logic            w_stall;
    logic            w_abort;
    logic            w_last;
    logic            w_dbl;
    logic            w_dbl_step;

`ifdef CPU_BUS_CYCLE_DOUBLE_SPEED_EN
    logic r_dbl;
    logic r_switch_pend;
    logic w_switch;

    // A switch request seen mid-access is parked until the next IDLE T0 without a request.
    assign w_switch = ce && (r_state == S_IDLE) && (r_t == '0) && !req_valid
                      && (r_switch_pend || speed_switch_req);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dbl         <= 1'b0;
            r_switch_pend <= 1'b0;
        end else if (ce) begin
            if (w_switch) begin
                r_dbl         <= ~r_dbl;
                r_switch_pend <= 1'b0;
            end else if (speed_switch_req) begin
                r_switch_pend <= 1'b1;
            end
        end
    end

    assign w_dbl        = r_dbl;
    assign w_dbl_step   = r_dbl ^ w_switch;
    assign double_speed = r_dbl;
`else
    assign w_dbl      = 1'b0;
    assign w_dbl_step = 1'b0;
`endif

    assign w_start = ce && (r_state == S_IDLE) && (r_t == '0) && req_valid;
    assign w_last  = w_dbl ? (r_t == T_WAIT) : (r_t == T_LAST1);
    assign w_abort = (r_state == S_WAIT) && bus_wait && (r_wait_cnt == W_MAX);
    assign w_stall = ((r_state == S_ACTIVE) && (r_t == T_WAIT) && bus_wait)
                     || ((r_state == S_WAIT) && bus_wait && (r_wait_cnt != W_MAX));

    always_comb begin
        w_t_adv = r_t + TW'(1);
        if (w_dbl_step) begin
            w_t_adv = (r_t >= T_WAIT) ? '0 : r_t + TW'(2);
        end else if (r_t == T_LAST1) begin
            w_t_adv = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_t        <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_t        <= w_t_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_t_nxt        = r_t;
        w_wait_cnt_nxt = r_wait_cnt;
        if (ce) begin
            if (!w_stall) begin
                w_t_nxt = w_t_adv;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        w_state_nxt = S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_stall) begin
                        w_state_nxt    = S_WAIT;
                        w_wait_cnt_nxt = WW'(1);
                    end else if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (w_stall) begin
                        if (r_wait_cnt != W_MAX) begin
                            w_wait_cnt_nxt = r_wait_cnt + WW'(1);
                        end
                    end else if (w_last) begin
                        // Double speed: the wait point is also the last T-cycle.
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_ACTIVE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        req_ready = ce && (r_state == S_IDLE) && (r_t == '0);
        commit    = ce && w_last && !w_stall;
        bus_en    = (r_state != S_IDLE);
        // Strobe drops in the last T-cycle for write hold time (single speed only).
        bus_wr    = bus_en && r_write && (w_dbl || (r_t != T_LAST1));
        phi       = (r_t < T_HALF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_write     <= 1'b0;
            r_abort     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_timeout   <= 1'b0;
            if (w_start) begin
                r_bus_addr  <= req_addr;
                r_bus_wdata <= req_wdata;
                r_write     <= req_write;
                r_abort     <= 1'b0;
            end
            if (ce && w_abort) begin
                r_abort   <= 1'b1;
                r_timeout <= 1'b1;
            end
            if (commit && (r_state != S_IDLE)) begin
                r_abort <= 1'b0;
                if (!r_write) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= (r_abort || w_abort) ? '1 : bus_rdata;
                end
            end
        end
    end

    assign t_cycle     = r_t;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_cpu_bus_cycle.sv
// Testbench for cpu_bus_cycle: directed steps with immediate-assert checks and a read-response scoreboard.
`timescale 1ns/1ps
module tb_cpu_bus_cycle;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int T_PER_M  = 4;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ce = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        req_ready;
    logic        commit;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [1:0]  t_cycle;
    logic        phi;
    logic [15:0] bus_addr;
    logic        bus_en;
    logic        bus_wr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = '0;
    logic        bus_wait = 1'b0;
    logic        timeout_err;
`ifdef CPU_BUS_CYCLE_DOUBLE_SPEED_EN
    logic        speed_switch_req = 1'b0;
    logic        double_speed;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    cpu_bus_cycle #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_PER_M(T_PER_M), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .commit(commit), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .t_cycle(t_cycle), .phi(phi), .bus_addr(bus_addr), .bus_en(bus_en), .bus_wr(bus_wr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_wait(bus_wait),
`ifdef CPU_BUS_CYCLE_DOUBLE_SPEED_EN
        .speed_switch_req(speed_switch_req), .double_speed(double_speed),
`endif
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every read response must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
            else check("rsp_rdata", rsp_rdata, exp_q.pop_front());
        end
    end

    // One access starting at T0 with ce held high; nwait > MAX_WAIT means bus_wait stuck.
    task automatic access(input logic wr, input logic [15:0] a, input logic [7:0] wd,
                          input logic [7:0] rd, input int nwait);
        int   stalled;
        logic aborted;
        aborted = (nwait > MAX_WAIT);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        bus_rdata = rd; bus_wait = 1'b0;
        #1;
        check("ready_t0", req_ready, 1);
        check("t0", t_cycle, 0);
        check("commit_t0", commit, 0);
        if (!wr) exp_q.push_back(aborted ? 8'hFF : rd);
        cyc; req_valid = 1'b0; req_addr = ~a; req_wdata = ~wd; #1;
        check("t1", t_cycle, 1);
        check("en_t1", bus_en, 1);
        check("wr_t1", bus_wr, wr);
        check("addr", bus_addr, a);
        if (wr) check("wdata", bus_wdata, wd);
        check("phi_t1", phi, 1);
        cyc; bus_wait = (nwait > 0); #1;
        check("t2", t_cycle, 2);
        check("wr_t2", bus_wr, wr);
        check("phi_t2", phi, 0);
        check("commit_t2", commit, 0);
        stalled = 0;
        while (stalled < nwait && stalled < MAX_WAIT) begin
            cyc; stalled++; bus_wait = (stalled < nwait); #1;
            check("t_frozen", t_cycle, 2);
            check("en_wait", bus_en, 1);
            check("wr_wait", bus_wr, wr);
            check("tmo_early", timeout_err, 0);
        end
        cyc; bus_wait = 1'b0; #1;
        check("t3", t_cycle, 3);
        check("commit_t3", commit, 1);
        check("wr_t3", bus_wr, 0);
        check("en_t3", bus_en, 1);
        check("timeout", timeout_err, aborted);
        cyc; #1;
        check("t_wrap", t_cycle, 0);
        check("en_release", bus_en, 0);
        check("rsp_valid", rsp_valid, !wr);
        check("tmo_clear", timeout_err, 0);
    endtask

    initial begin
        int tm;
        #1 reset = 1'b1;
        #2;
        check("rst_en", bus_en, 0);
        check("rst_wr", bus_wr, 0);
        check("rst_commit", commit, 0);
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_t", t_cycle, 0);
        check("rst_phi", phi, 1);
        check("rst_tmo", timeout_err, 0);
        check("rst_addr", bus_addr, 0);

        cyc; reset = 1'b0; ce = 1'b1;
        // Internal M-cycle: late req_valid and bus_wait must both be ignored.
        bus_wait = 1'b1; #1;
        check("int_ready", req_ready, 1);
        cyc; req_valid = 1'b1; #1;
        check("int_t1", t_cycle, 1);
        check("int_en1", bus_en, 0);
        check("int_ready1", req_ready, 0);
        cyc; #1;
        check("int_t2", t_cycle, 2);
        cyc; #1;
        check("int_t3", t_cycle, 3);
        check("int_commit", commit, 1);
        check("int_en3", bus_en, 0);
        cyc; req_valid = 1'b0; bus_wait = 1'b0; #1;
        check("int_wrap", t_cycle, 0);

        access(1'b0, 16'h1234, 8'h00, 8'hAB, 0);
        access(1'b1, 16'hC000, 8'h5A, 8'h00, 0);
        access(1'b0, 16'h8001, 8'h00, 8'h77, 3);
        access(1'b0, 16'hFF10, 8'h00, 8'h3C, 100);
        access(1'b0, 16'h0042, 8'h00, 8'h99, 0);

        // ce high one clock in three during a read.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h2000; bus_rdata = 8'h5E;
        exp_q.push_back(8'h5E);
        #1;
        check("ce_ready", req_ready, 1);
        tm = 0;
        for (int k = 0; k < 12; k++) begin
            cyc;
            if (ce) tm = (tm + 1) % T_PER_M;
            req_valid = 1'b0;
            ce = ((k + 1) % 3 == 0);
            #1;
            check("ce_t", t_cycle, tm);
            check("ce_commit", commit, (ce && tm == 3));
            check("ce_en", bus_en, (tm != 0));
        end

        // Reset asserted at T2 of a write releases the bus at once.
        ce = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 16'hC123; req_wdata = 8'h11;
        cyc; req_valid = 1'b0; #1;
        check("rw_t1", t_cycle, 1);
        check("rw_wr1", bus_wr, 1);
        cyc; #1;
        check("rw_t2", t_cycle, 2);
        check("rw_wr2", bus_wr, 1);
        reset = 1'b1; #1;
        check("rw_en_rst", bus_en, 0);
        check("rw_wr_rst", bus_wr, 0);
        check("rw_t_rst", t_cycle, 0);
        check("rw_rsp_rst", rsp_valid, 0);
        cyc; cyc; reset = 1'b0; #1;
        check("rw_restart", req_ready, 1);
        access(1'b0, 16'h0300, 8'h00, 8'hC6, 0);

`ifdef CPU_BUS_CYCLE_DOUBLE_SPEED_EN
        speed_switch_req = 1'b1; #1;
        cyc; speed_switch_req = 1'b0; #1;
        check("ds_on", double_speed, 1);
        check("ds_t2", t_cycle, 2);
        check("ds_commit_int", commit, 1);
        cyc; req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h4444; bus_rdata = 8'h21;
        exp_q.push_back(8'h21);
        #1;
        check("ds_ready", req_ready, 1);
        cyc; req_valid = 1'b0; speed_switch_req = 1'b1; #1;
        check("ds_acc_t2", t_cycle, 2);
        check("ds_acc_en", bus_en, 1);
        check("ds_acc_commit", commit, 1);
        cyc; speed_switch_req = 1'b0; #1;
        check("ds_acc_wrap", t_cycle, 0);
        check("ds_deferred", double_speed, 1);
        check("ds_rsp", rsp_valid, 1);
        cyc; #1;
        check("ds_off", double_speed, 0);
        check("ds_single_t1", t_cycle, 1);
        cyc; cyc; cyc; #1;
`endif

        cyc; cyc;
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
